perceptron_classifier: RTL and testbench

//  Inference-side counterpart of the perceptron training datapath. It holds a trained weight set
//  (w1, w2, b) and streams labelled samples (x1, x2, t) through a 2-stage multiply/accumulate

---
 rtl/neuron_pkg.sv | 19 +
 rtl/perceptron_mac2.sv | 38 +++
 rtl/perceptron_classifier.sv | 160 ++++++++++++++++
 tb/tb_perceptron_classifier.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared widths, label encodings and FSM states
// for the perceptron inference datapath.
package neuron_pkg;

  localparam int NEURON_XW   = 7;
  localparam int NEURON_WW   = 14;
  localparam int NEURON_CNTW = 32;

  localparam logic [1:0] LABEL_POS = 2'b01;
  localparam logic [1:0] LABEL_NEG = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/perceptron_mac2.sv
// Stage 1: two signed products plus label sign,
// advancing only when the pipeline is enabled.
module perceptron_mac2 #(
  parameter int XW = 7,
  parameter int WW = 14,
  parameter int PW = XW + WW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 inFire,
  input  logic signed [XW-1:0] x1,
  input  logic signed [XW-1:0] x2,
  input  logic signed [WW-1:0] w1,
  input  logic signed [WW-1:0] w2,
  input  logic                 tSign,
  output logic                 v1,
  output logic signed [PW-1:0] p1,
  output logic signed [PW-1:0] p2,
  output logic                 t1
);

  // Register products; hold everything under backpressure
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      p1 <= '0;
      p2 <= '0;
      t1 <= 1'b0;
    end else if (en) begin
      v1 <= inFire;
      p1 <= PW'(x1) * PW'(w1);
      p2 <= PW'(x2) * PW'(w2);
      t1 <= tSign;
    end
  end

endmodule

// File: rtl/perceptron_classifier.sv
// Perceptron inference: 2-stage MAC pipeline,
// batch FSM and result counters.
module perceptron_classifier
  import neuron_pkg::*;
#(
  parameter int XW   = NEURON_XW,
  parameter int WW   = NEURON_WW,
  parameter int CNTW = NEURON_CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wLoad,
  input  logic [WW-1:0]   w1In,
  input  logic [WW-1:0]   w2In,
  input  logic [WW-1:0]   bIn,
  input  logic            start,
  input  logic [CNTW-1:0] nIn,
  input  logic            inValid,
  output logic            inReady,
  input  logic [XW-1:0]   x1In,
  input  logic [XW-1:0]   x2In,
  input  logic [1:0]      tIn,
  output logic            outValid,
  input  logic            outReady,
  output logic            yClass,
  output logic            match,
  output logic [CNTW-1:0] sampleCnt,
  output logic [CNTW-1:0] correctCnt,
  output logic            done,
  output logic            allMatch
);

  localparam int PW = XW + WW;
  localparam int SW = PW + 1;

  state_t state;

  logic signed [WW-1:0] w1;
  logic signed [WW-1:0] w2;
  logic signed [WW-1:0] b;
  logic [CNTW-1:0]      n;
  logic [CNTW-1:0]      accepted;

  logic                 en;
  logic                 inFire;
  logic                 outFire;
  logic                 idleLike;
  logic                 v1;
  logic                 t1;
  logic signed [PW-1:0] p1;
  logic signed [PW-1:0] p2;
  logic signed [SW-1:0] sum;
  logic                 unusedT;

  // Only the sign bit of the label matters
  assign unusedT  = tIn[0];

  assign idleLike = (state == IDLE) || (state == DONE);
  assign en       = !outValid || outReady;
  assign inReady  = (state == RUN) && (accepted < n) && en;
  assign inFire   = inValid && inReady;
  assign outFire  = outValid && outReady;
  assign sum      = SW'(p1) + SW'(p2) + SW'(b);

  perceptron_mac2 #(
    .XW(XW),
    .WW(WW),
    .PW(PW)
  ) uMac (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .inFire(inFire),
    .x1    (x1In),
    .x2    (x2In),
    .w1    (w1),
    .w2    (w2),
    .tSign (tIn[1]),
    .v1    (v1),
    .p1    (p1),
    .p2    (p2),
    .t1    (t1)
  );

  // Weights change only between batches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w1 <= '0;
      w2 <= '0;
      b  <= '0;
    end else if (wLoad && idleLike) begin
      w1 <= w1In;
      w2 <= w2In;
      b  <= bIn;
    end
  end

  // Stage 2: sum, sign decision and match flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outValid <= 1'b0;
      yClass   <= 1'b0;
      match    <= 1'b0;
    end else if (en) begin
      outValid <= v1;
      yClass   <= sum[SW-1];
      match    <= (sum[SW-1] == t1);
    end
  end

  // Batch FSM with handshake counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      n          <= '0;
      accepted   <= '0;
      sampleCnt  <= '0;
      correctCnt <= '0;
      done       <= 1'b0;
      allMatch   <= 1'b0;
    end else begin
      if (inFire) begin
        accepted <= accepted + CNTW'(1);
      end
      if (outFire) begin
        sampleCnt <= sampleCnt + CNTW'(1);
        if (match) begin
          correctCnt <= correctCnt + CNTW'(1);
        end
      end
      unique case (1'b1)
        idleLike: begin
          if (start) begin
            state      <= RUN;
            n          <= nIn;
            accepted   <= '0;
            sampleCnt  <= '0;
            correctCnt <= '0;
            done       <= 1'b0;
            allMatch   <= 1'b0;
          end
        end
        state == RUN: begin
          if (accepted == n) begin
            state <= DRAIN;
          end
        end
        state == DRAIN: begin
          if (!v1 && !outValid) begin
            state    <= DONE;
            done     <= 1'b1;
            allMatch <= (correctCnt == n);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_classifier.sv
// Self-checking bench: fixed vectors, corner
// sequences and randomized batches vs a model.
module tb_perceptron_classifier;

  localparam int XW   = 7;
  localparam int WW   = 14;
  localparam int CNTW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            wLoad;
  logic [WW-1:0]   w1In;
  logic [WW-1:0]   w2In;
  logic [WW-1:0]   bIn;
  logic            start;
  logic [CNTW-1:0] nIn;
  logic            inValid;
  logic            inReady;
  logic [XW-1:0]   x1In;
  logic [XW-1:0]   x2In;
  logic [1:0]      tIn;
  logic            outValid;
  logic            outReady;
  logic            yClass;
  logic            match;
  logic [CNTW-1:0] sampleCnt;
  logic [CNTW-1:0] correctCnt;
  logic            done;
  logic            allMatch;

  perceptron_classifier #(
    .XW(XW),
    .WW(WW),
    .CNTW(CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wLoad     (wLoad),
    .w1In      (w1In),
    .w2In      (w2In),
    .bIn       (bIn),
    .start     (start),
    .nIn       (nIn),
    .inValid   (inValid),
    .inReady   (inReady),
    .x1In      (x1In),
    .x2In      (x2In),
    .tIn       (tIn),
    .outValid  (outValid),
    .outReady  (outReady),
    .yClass    (yClass),
    .match     (match),
    .sampleCnt (sampleCnt),
    .correctCnt(correctCnt),
    .done      (done),
    .allMatch  (allMatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         w1;
    int         w2;
    int         b;
    int         x1;
    int         x2;
    logic [1:0] t;
    logic       y;
    logic       m;
  } vec_t;

  vec_t tbl[7];

  int nVec = 0;
  int nErr = 0;

  int gw1 = 0;
  int gw2 = 0;
  int gb  = 0;

  int         sx1[$];
  int         sx2[$];
  logic [1:0] st[$];
  logic       ey[$];
  logic       em[$];

  task automatic check(input string name,
                       input longint act,
                       input longint exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Reference: plain integer dot product
  function automatic logic [1:0] model(
    input int x1, input int x2,
    input int w1, input int w2,
    input int b, input logic [1:0] t);
    int   s;
    logic y;
    s = x1 * w1 + x2 * w2 + b;
    y = (s < 0);
    return {y, (y == t[1])};
  endfunction

  task automatic clearQ();
    sx1.delete();
    sx2.delete();
    st.delete();
    ey.delete();
    em.delete();
  endtask

  task automatic pushModel(input int x1,
                           input int x2,
                           input logic [1:0] t);
    logic [1:0] r;
    r = model(x1, x2, gw1, gw2, gb, t);
    sx1.push_back(x1);
    sx2.push_back(x2);
    st.push_back(t);
    ey.push_back(r[1]);
    em.push_back(r[0]);
  endtask

  task automatic pushFixed(input int x1,
                           input int x2,
                           input logic [1:0] t,
                           input logic y,
                           input logic m);
    sx1.push_back(x1);
    sx2.push_back(x2);
    st.push_back(t);
    ey.push_back(y);
    em.push_back(m);
  endtask

  task automatic loadW(input int a,
                       input int c,
                       input int d);
    @(negedge clk);
    wLoad = 1'b1;
    w1In  = WW'(a);
    w2In  = WW'(c);
    bIn   = WW'(d);
    @(negedge clk);
    wLoad = 1'b0;
    gw1   = a;
    gw2   = c;
    gb    = d;
  endtask

  task automatic startBatch(input int n);
    @(negedge clk);
    start = 1'b1;
    nIn   = CNTW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runBatch(input int n,
                          input int stall,
                          input int readyPct,
                          input int validPct);
    int acc;
    int rec;
    int cyc;
    int corr;
    int w;
    acc  = 0;
    rec  = 0;
    cyc  = 0;
    corr = 0;
    while (rec < n && cyc < 400) begin
      @(negedge clk);
      outReady = (cyc >= stall) &&
                 ($urandom_range(99) < readyPct);
      if (acc < n) begin
        inValid = ($urandom_range(99) < validPct);
        x1In    = XW'(sx1[acc]);
        x2In    = XW'(sx2[acc]);
        tIn     = st[acc];
      end else begin
        inValid = 1'b1;
      end
      #1;
      if (acc >= n)
        check("noExtraAccept", inReady, 0);
      if (outValid) begin
        if (rec < n) begin
          check("yClass", yClass, ey[rec]);
          check("match", match, em[rec]);
          if (outReady) begin
            corr += int'(em[rec]);
            rec++;
          end
        end else begin
          check("extraOutput", outValid, 0);
        end
      end
      if (inValid && inReady)
        acc++;
      if (stall > 0 && cyc == stall - 1)
        check("bpAccepted", acc, 2);
      cyc++;
    end
    if (rec < n)
      check("resultTimeout", rec, n);
    @(negedge clk);
    inValid  = 1'b0;
    outReady = 1'b1;
    w = 0;
    while (!done && w < 8) begin
      @(negedge clk);
      w++;
    end
    check("done", done, 1);
    check("sampleCnt", sampleCnt, n);
    check("correctCnt", correctCnt, corr);
    check("allMatch", allMatch, corr == n);
  endtask

  initial begin
    int acc;
    int cyc;
    int nb;
    int w;

    tbl[0] = '{3, -2, 5, 1, 4, 2'b01, 1'b0, 1'b1};
    tbl[1] = '{3, -2, 5, -2, 1, 2'b11, 1'b1, 1'b1};
    tbl[2] = '{3, -2, 5, 1, 4, 2'b11, 1'b0, 1'b0};
    tbl[3] = '{-1, 0, 0, 7, 0, 2'b01, 1'b1, 1'b0};
    tbl[4] = '{-8192, -8192, 8191, -64, -64,
               2'b11, 1'b0, 1'b0};
    tbl[5] = '{-8192, -8192, -8192, 63, 63,
               2'b11, 1'b1, 1'b1};
    tbl[6] = '{0, 0, 0, 0, 0, 2'b10, 1'b0, 1'b0};

    rst      = 1'b0;
    wLoad    = 1'b0;
    w1In     = '0;
    w2In     = '0;
    bIn      = '0;
    start    = 1'b0;
    nIn      = '0;
    inValid  = 1'b0;
    x1In     = '0;
    x2In     = '0;
    tIn      = 2'b00;
    outReady = 1'b1;

    repeat (2) @(negedge clk);
    check("rstInReady", inReady, 0);
    check("rstOutValid", outValid, 0);
    check("rstMatch", match, 0);
    check("rstDone", done, 0);
    check("rstSampleCnt", sampleCnt, 0);
    rst = 1'b1;

    // Fixed vectors, one sample per batch
    for (int i = 0; i < 7; i++) begin
      loadW(tbl[i].w1, tbl[i].w2, tbl[i].b);
      clearQ();
      pushFixed(tbl[i].x1, tbl[i].x2, tbl[i].t,
                tbl[i].y, tbl[i].m);
      startBatch(1);
      runBatch(1, 0, 100, 100);
    end

    // Two-sample batch, both correct
    loadW(3, -2, 5);
    clearQ();
    pushFixed(1, 4, 2'b01, 1'b0, 1'b1);
    pushFixed(-2, 1, 2'b11, 1'b1, 1'b1);
    startBatch(2);
    runBatch(2, 0, 100, 100);

    // Backpressure with a stalled consumer
    clearQ();
    for (int i = 0; i < 4; i++)
      pushModel($urandom_range(127) - 64,
                $urandom_range(127) - 64,
                2'($urandom_range(3)));
    startBatch(4);
    runBatch(4, 5, 100, 100);

    // Empty batch
    startBatch(0);
    inValid = 1'b1;
    w = 0;
    while (!done && w < 3) begin
      @(negedge clk);
      #1;
      check("n0InReady", inReady, 0);
      w++;
    end
    inValid = 1'b0;
    check("n0Done", done, 1);
    check("n0SampleCnt", sampleCnt, 0);
    check("n0CorrectCnt", correctCnt, 0);
    check("n0AllMatch", allMatch, 1);

    // wLoad during RUN must be ignored
    loadW(3, -2, 5);
    startBatch(1);
    wLoad = 1'b1;
    w1In  = WW'(-1);
    w2In  = '0;
    bIn   = '0;
    @(negedge clk);
    wLoad = 1'b0;
    clearQ();
    pushFixed(7, 0, 2'b01, 1'b0, 1'b1);
    runBatch(1, 0, 100, 100);

    // wLoad together with start in DONE
    @(negedge clk);
    wLoad = 1'b1;
    w1In  = WW'(-1);
    w2In  = '0;
    bIn   = '0;
    start = 1'b1;
    nIn   = 1;
    @(negedge clk);
    wLoad = 1'b0;
    start = 1'b0;
    gw1   = -1;
    gw2   = 0;
    gb    = 0;
    clearQ();
    pushFixed(7, 0, 2'b01, 1'b1, 1'b0);
    runBatch(1, 0, 100, 100);

    // Asynchronous reset mid-batch
    loadW(5, 7, -3);
    clearQ();
    for (int i = 0; i < 5; i++)
      pushModel(i + 1, -i, 2'b01);
    startBatch(5);
    acc = 0;
    cyc = 0;
    while (acc < 2 && cyc < 20) begin
      @(negedge clk);
      inValid  = 1'b1;
      outReady = 1'b1;
      x1In     = XW'(sx1[acc]);
      x2In     = XW'(sx2[acc]);
      tIn      = st[acc];
      #1;
      if (inReady)
        acc++;
      cyc++;
    end
    check("preRstAccepted", acc, 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arstOutValid", outValid, 0);
    check("arstYClass", yClass, 0);
    check("arstMatch", match, 0);
    check("arstSampleCnt", sampleCnt, 0);
    check("arstCorrectCnt", correctCnt, 0);
    check("arstDone", done, 0);
    check("arstAllMatch", allMatch, 0);
    check("arstInReady", inReady, 0);
    @(negedge clk);
    rst = 1'b1;
    gw1 = 0;
    gw2 = 0;
    gb  = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("idleInReady", inReady, 0);
      check("idleOutValid", outValid, 0);
    end
    inValid = 1'b0;

    // Randomized batches
    for (int k = 0; k < 8; k++) begin
      loadW($urandom_range(16383) - 8192,
            $urandom_range(16383) - 8192,
            $urandom_range(16383) - 8192);
      clearQ();
      nb = $urandom_range(12, 1);
      for (int i = 0; i < nb; i++)
        pushModel($urandom_range(127) - 64,
                  $urandom_range(127) - 64,
                  2'($urandom_range(3)));
      startBatch(nb);
      runBatch(nb, 0, 60, 70);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nErr);
    $finish;
  end

endmodule
